// File: rtl/mic_pkg.sv
// Shared definitions for the stereo PDM microphone capture sequencer.
package mic_pkg;

    // Default widths for the divider and settle counters.
    localparam int DIV_W_DEF    = 8;
    localparam int SETTLE_W_DEF = 16;

    // Reset values of the divider and settle configuration.
    localparam int DIV_RST    = 3;
    localparam int SETTLE_RST = 0;

    // Sequencer states, encoded as plain constants for older tooling.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_DRAIN  = 2'd3;

endpackage

// File: rtl/mic_capture_ctrl_if.sv
// Config, control and capture-result bundle between the register block,
// the sequencer and the decimation filters.
interface mic_capture_ctrl_if
    import mic_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
);
    logic                cfg_we;
    logic [DIV_W-1:0]    cfg_div;
    logic [SETTLE_W-1:0] cfg_settle;
    logic                start;
    logic                stop;
    logic                pdm_l;
    logic                pdm_r;
    logic                pdm_valid;
    logic                busy;
    logic                settled;

    // Register block / host side.
    modport master (
        output cfg_we, cfg_div, cfg_settle, start, stop,
        input  pdm_l, pdm_r, pdm_valid, busy, settled
    );

    // Sequencer side.
    modport slave (
        input  cfg_we, cfg_div, cfg_settle, start, stop,
        output pdm_l, pdm_r, pdm_valid, busy, settled
    );
endinterface

// File: rtl/mic_clk_div.sv
// Mic-clock prescaler: half-period of (div+1) clk cycles, with the active
// divider only reloaded at a period boundary so no phase is ever shortened.
module mic_clk_div
    import mic_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_shadow,
    output logic             mic_clk,
    output logic             rise,
    output logic             fall
);
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic             mic_clk_q, mic_clk_d;
    logic             toggle;

    assign toggle  = en && (count_q == div_active_q);
    assign rise    = toggle && !mic_clk_q;
    assign fall    = toggle && mic_clk_q;
    assign mic_clk = mic_clk_q;

    // Next-state for the counter, clock level and active divider.
    always_comb begin
        count_d      = count_q;
        mic_clk_d    = mic_clk_q;
        div_active_d = div_active_q;
        if (!en) begin
            // Parked: clock low, counter cleared, divider tracks the shadow.
            count_d      = '0;
            mic_clk_d    = 1'b0;
            div_active_d = div_shadow;
        end else begin
            count_d   = toggle ? '0 : count_q + 1'b1;
            mic_clk_d = toggle ? ~mic_clk_q : mic_clk_q;
            // Falling edge ends a period: the only safe point to change div.
            if (fall) begin
                div_active_d = div_shadow;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            mic_clk_q    <= 1'b0;
            div_active_q <= DIV_W'(DIV_RST);
        end else begin
            count_q      <= count_d;
            mic_clk_q    <= mic_clk_d;
            div_active_q <= div_active_d;
        end
    end
endmodule

// File: rtl/mic_capture_ctrl.sv
// Stereo PDM microphone sequencer: settle, run and orderly stop, with
// dual-edge capture of the shared data line into left/right bit pairs.
module mic_capture_ctrl
    import mic_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mic_capture_ctrl_if.slave bus,
    input  logic              pdm_in,
    output logic              mic_clk
);
    state_t              state_q, state_d;
    logic [DIV_W-1:0]    shadow_div_q, shadow_div_d;
    logic [SETTLE_W-1:0] shadow_settle_q, shadow_settle_d;
    logic [SETTLE_W-1:0] settle_active_q, settle_active_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                drain_emit_q, drain_emit_d;
    logic                r_hold_q, r_hold_d;
    logic                pdm_l_q, pdm_l_d;
    logic                pdm_r_q, pdm_r_d;
    logic                pdm_valid_q, pdm_valid_d;
    logic                rise, fall;
    logic                settle_done;

    mic_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q != ST_IDLE),
        .div_shadow (shadow_div_q),
        .mic_clk    (mic_clk),
        .rise       (rise),
        .fall       (fall)
    );

    // Extra bit so the +1 compare cannot wrap at the maximum settle count.
    assign settle_done = (({1'b0, settle_cnt_q} + 1'b1) == {1'b0, settle_active_q});

    // Shadow config registers accept writes in any state.
    always_comb begin
        shadow_div_d    = shadow_div_q;
        shadow_settle_d = shadow_settle_q;
        if (bus.cfg_we) begin
            shadow_div_d    = bus.cfg_div;
            shadow_settle_d = bus.cfg_settle;
        end
    end

    // Sequencer: IDLE -> SETTLE -> RUN -> DRAIN -> IDLE.
    always_comb begin
        state_d         = state_q;
        settle_active_d = settle_active_q;
        settle_cnt_d    = settle_cnt_q;
        drain_emit_d    = drain_emit_q;
        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous stop, which is dropped.
                if (bus.start) begin
                    settle_active_d = shadow_settle_q;
                    settle_cnt_d    = '0;
                    state_d         = (shadow_settle_q == '0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.stop) begin
                    // The draining period never ran in RUN: no pair emitted.
                    drain_emit_d = 1'b0;
                    state_d      = ST_DRAIN;
                end else if (fall) begin
                    if (settle_done) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    drain_emit_d = 1'b1;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish the current period so mic_clk ends low.
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Right mic drives on the low phase, left mic on the high phase.
    always_comb begin
        r_hold_d    = rise ? pdm_in : r_hold_q;
        pdm_l_d     = fall ? pdm_in : pdm_l_q;
        pdm_r_d     = fall ? r_hold_q : pdm_r_q;
        pdm_valid_d = fall && ((state_q == ST_RUN) ||
                               ((state_q == ST_DRAIN) && drain_emit_q));
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            shadow_div_q    <= DIV_W'(DIV_RST);
            shadow_settle_q <= SETTLE_W'(SETTLE_RST);
            settle_active_q <= SETTLE_W'(SETTLE_RST);
            settle_cnt_q    <= '0;
            drain_emit_q    <= 1'b0;
            r_hold_q        <= 1'b0;
            pdm_l_q         <= 1'b0;
            pdm_r_q         <= 1'b0;
            pdm_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            shadow_div_q    <= shadow_div_d;
            shadow_settle_q <= shadow_settle_d;
            settle_active_q <= settle_active_d;
            settle_cnt_q    <= settle_cnt_d;
            drain_emit_q    <= drain_emit_d;
            r_hold_q        <= r_hold_d;
            pdm_l_q         <= pdm_l_d;
            pdm_r_q         <= pdm_r_d;
            pdm_valid_q     <= pdm_valid_d;
        end
    end

    assign bus.pdm_l     = pdm_l_q;
    assign bus.pdm_r     = pdm_r_q;
    assign bus.pdm_valid = pdm_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.settled   = (state_q == ST_RUN);
endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
Sequencer for a stereo PDM MEMS microphone pair. It owns the mic-clock prescaler and sequences power-up settling, run and orderly stop. It captures the shared PDM data line on both clock phases and emits left/right bit pairs with a valid strobe. The block sits between the Wishbone config registers and the PDM decimation filters.

Parameters:
DIV_W, 8, width of divider value (half-period = div+1 clk cycles)
SETTLE_W, 16, width of settle count (mic_clk periods discarded after start)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cfg_we  in  1  write strobe for cfg_div / cfg_settle shadow registers
cfg_div  in  DIV_W  requested half-period minus one
cfg_settle  in  SETTLE_W  requested number of settle periods
start  in  1  one-cycle pulse: begin capture
stop  in  1  one-cycle pulse: end capture
pdm_in  in  1  shared PDM data line from both mics
mic_clk  out  1  clock to microphones
pdm_l  out  1  left-channel bit (sampled at mic_clk falling edge)
pdm_r  out  1  right-channel bit (sampled at mic_clk rising edge)
pdm_valid  out  1  one-cycle strobe: pdm_l/pdm_r hold a new pair
busy  out  1  state != IDLE
settled  out  1  state == RUN

Behaviour:
- Reset: state=IDLE, count=0, mic_clk=0, pdm_l=0, pdm_r=0, pdm_valid=0, shadow div=3, shadow settle=0, active div=3.
- Shadow regs are written on cfg_we in any state. Active div loads from shadow in IDLE every cycle. In other states it loads only on a fall event (period boundary), so there are no glitched half-periods. Active settle is latched on start.
- Divider: count is held at 0 in IDLE. Otherwise count increments each cycle. When count==div_active, count<=0 and mic_clk<=~mic_clk (toggle event). div=0 gives a toggle every cycle.
- Events: rise = toggle && mic_clk==0; fall = toggle && mic_clk==1.
- On rise: r_hold<=pdm_in.
- On fall: pdm_l<=pdm_in, pdm_r<=r_hold. pdm_valid=1 for exactly that next cycle, and only if the state at the fall is RUN or DRAIN.
- FSM:
  - IDLE: start -> SETTLE, or -> RUN if settle_active==0. mic_clk is low.
  - SETTLE: settle_cnt increments on each fall. On the fall where settle_cnt+1==settle_active -> RUN. stop -> DRAIN.
  - RUN: capture pairs continuously. stop -> DRAIN.
  - DRAIN: on the next fall, the final pair is emitted (if a full period completed in RUN) and state -> IDLE. mic_clk ends low and count returns to 0.
- start outside IDLE is ignored. stop in IDLE is ignored. If start and stop arrive in the same cycle in IDLE, start wins and stop is dropped.
- cfg_we and a fall in the same cycle: the active div takes the old shadow value, and the new value applies at the next fall.
- rst mid-capture returns every output to its reset value on the next clk. mic_clk drops low immediately with no completion of the period.
- Period = 2*(div+1) clk cycles. Pair throughput is one pdm_valid per mic_clk period.

Decomposition:
- Shared package mic_pkg holds:
  - state typedef (IDLE, SETTLE, RUN, DRAIN);
  - DIV_RST=3, SETTLE_RST=0;
  - default widths.
- Sub-module mic_clk_div contains the counter, toggle, active-div load-on-boundary logic and rise/fall event outputs. It has an enable input and holds clock low when disabled. The FSM and capture logic stay in the top module.

Test Plan:
- Reset then div=3, settle=0, start: mic_clk high 4 clk / low 4 clk. First pdm_valid arrives 1 cycle after the first fall. Repeats every 8 clk. busy=1, settled=1.
- pdm_in driven 1 while mic_clk low and 0 while high: every strobe shows pdm_r=1, pdm_l=0. Swap the drive: pdm_r=0, pdm_l=1.
- settle=3, div=1: no pdm_valid during the first 3 periods (12 clk). settled rises after the 3rd fall. Valid strobes begin on the 4th period.
- Write div=0 mid-RUN, off-boundary: the current period completes at 8 clk with div=3, then the period becomes 2 clk. No high or low phase has any other length.
- stop mid-high-phase in RUN: exactly one more pdm_valid occurs, then busy=0 and mic_clk stays low. start+stop in the same IDLE cycle → capture starts.
- rst asserted mid-RUN with mic_clk=1: next cycle mic_clk=0, pdm_valid=0, busy=0, count=0. A subsequent start behaves as in the first scenario.
